// File: rtl/mips_alu_pc_unit.sv
`timescale 1ns/1ps
// Multicycle MIPS datapath slice: ALU control decode, 32-bit ALU, ALUOut register
// and the program counter with its three-way next-PC source mux.
module mips_alu_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [1:0]  pc_source,
  input  logic [31:0] jump_addr,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] alu_out,
  output logic [31:0] pc_next,
  output logic [31:0] pc
);

  logic pc_load;

  // R-type instructions defer to funct; everything else is fixed by the control unit
  always_comb begin
    alu_ctl = 4'b1111;
    case (alu_op)
      2'b00: alu_ctl = 4'b0010;
      2'b01: alu_ctl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctl = 4'b0010;
          6'b100010: alu_ctl = 4'b0110;
          6'b100100: alu_ctl = 4'b0000;
          6'b100101: alu_ctl = 4'b0001;
          6'b100111: alu_ctl = 4'b1100;
          6'b101010: alu_ctl = 4'b0111;
          default:   alu_ctl = 4'b1111;
        endcase
      end
      default: alu_ctl = 4'b1111;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_ctl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  always_comb begin
    pc_next = jump_addr;
    case (pc_source)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      default: pc_next = jump_addr;
    endcase
  end

  // Branch-equal uses this cycle's zero so the compare and the PC update share one edge
  assign pc_load = pc_write | (pc_write_cond & zero);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_out <= 32'd0;
      pc      <= RESET_PC;
    end else begin
      alu_out <= alu_result;
      if (pc_load) begin
        pc <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_pc_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for mips_alu_pc_unit: expected values are queued when stimulus
// is driven and compared once the combinational or registered outputs are due.
module tb_mips_alu_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int SEL_CTL    = 0;
  localparam int SEL_RESULT = 1;
  localparam int SEL_ZERO   = 2;
  localparam int SEL_PCNEXT = 3;
  localparam int SEL_ALUOUT = 4;
  localparam int SEL_PC     = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } entry_t;

  logic        clock;
  logic        reset_n;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  pc_source;
  logic [31:0] jump_addr;
  logic        pc_write;
  logic        pc_write_cond;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] alu_out;
  logic [31:0] pc_next;
  logic [31:0] pc;

  entry_t      comb_q[$];
  entry_t      reg_q[$];
  int          checks;
  int          errors;
  logic [31:0] model_pc;
  logic [31:0] model_alu_out;

  mips_alu_pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .alu_op(alu_op),
    .funct(funct),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .pc_source(pc_source),
    .jump_addr(jump_addr),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .alu_ctl(alu_ctl),
    .alu_result(alu_result),
    .zero(zero),
    .alu_out(alu_out),
    .pc_next(pc_next),
    .pc(pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h27:   return 4'b1100;
      6'h2A:   return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] wide;
    case (ctl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: begin wide = {1'b0, a} + {1'b0, b}; return wide[31:0]; end
      4'b0110: begin wide = {1'b0, a} - {1'b0, b}; return wide[31:0]; end
      4'b0111: begin
        if (a[31] != b[31]) return {31'd0, a[31]};
        return {31'd0, a < b};
      end
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_CTL:    return {28'd0, alu_ctl};
      SEL_RESULT: return alu_result;
      SEL_ZERO:   return {31'd0, zero};
      SEL_PCNEXT: return pc_next;
      SEL_ALUOUT: return alu_out;
      default:    return pc;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectComb(input string tag, input int sel, input logic [31:0] exp);
    entry_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    comb_q.push_back(e);
  endtask

  task automatic expectReg(input string tag, input int sel, input logic [31:0] exp);
    entry_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    reg_q.push_back(e);
  endtask

  task automatic drainComb();
    entry_t e;
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      checkOutput(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic drainReg();
    entry_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      checkOutput(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Drives one cycle's inputs at the falling edge and queues the model's predictions
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] src, input logic [31:0] jaddr,
                               input logic pw, input logic pwc);
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic [31:0] nxt;
    @(negedge clock);
    alu_op = op; funct = fn; alu_a = a; alu_b = b;
    pc_source = src; jump_addr = jaddr; pc_write = pw; pc_write_cond = pwc;
    ctl = ref_ctl(op, fn);
    res = ref_alu(ctl, a, b);
    z   = (res == 32'd0);
    nxt = (src == 2'b00) ? res : (src == 2'b01) ? model_alu_out : jaddr;
    expectComb({tag, "_ctl"}, SEL_CTL, {28'd0, ctl});
    expectComb({tag, "_result"}, SEL_RESULT, res);
    expectComb({tag, "_zero"}, SEL_ZERO, {31'd0, z});
    expectComb({tag, "_pcnext"}, SEL_PCNEXT, nxt);
    if (!reset_n) begin
      model_pc      = RESET_PC;
      model_alu_out = 32'd0;
    end else begin
      if (pw | (pwc & z)) model_pc = nxt;
      model_alu_out = res;
    end
    expectReg({tag, "_pc"}, SEL_PC, model_pc);
    expectReg({tag, "_aluout"}, SEL_ALUOUT, model_alu_out);
  endtask

  task automatic stepClock();
    #1;
    drainComb();
    @(posedge clock);
    #1;
    drainReg();
  endtask

  task automatic resetDut();
    #2;
    reset_n = 1'b0;
    model_pc      = RESET_PC;
    model_alu_out = 32'd0;
    #1;
    expectReg("async_rst_pc", SEL_PC, RESET_PC);
    expectReg("async_rst_aluout", SEL_ALUOUT, 32'd0);
    drainReg();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [5:0] funct_pool [7];

  initial begin
    checks = 0;
    errors = 0;
    funct_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
    reset_n = 1'b0;
    alu_op = 2'b00; funct = 6'd0; alu_a = 32'd3; alu_b = 32'd4;
    pc_source = 2'b00; jump_addr = 32'd0; pc_write = 1'b0; pc_write_cond = 1'b0;
    model_pc = RESET_PC;
    model_alu_out = 32'd0;

    #3;
    expectReg("reset_pc", SEL_PC, RESET_PC);
    expectReg("reset_aluout", SEL_ALUOUT, 32'd0);
    expectComb("reset_comb_result", SEL_RESULT, 32'd7);
    drainComb();
    drainReg();
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("sub_eq", 2'b10, 6'h22, 32'd5, 32'd5, 2'b00, 32'd0, 1'b0, 1'b0);
    expectComb("sub_eq_ctl_lit", SEL_CTL, 32'h6);
    expectComb("sub_eq_zero_lit", SEL_ZERO, 32'd1);
    stepClock();
    applyStimulus("slt_neg", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 1'b0, 1'b0);
    expectComb("slt_neg_lit", SEL_RESULT, 32'd1);
    stepClock();
    applyStimulus("nor", 2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_00F0, 2'b00, 32'd0, 1'b0, 1'b0);
    expectComb("nor_lit", SEL_RESULT, 32'hF0F0_FF0F);
    stepClock();
    applyStimulus("bad_funct", 2'b10, 6'h00, 32'h1234, 32'h5678, 2'b00, 32'd0, 1'b0, 1'b0);
    expectComb("bad_funct_ctl_lit", SEL_CTL, 32'hF);
    expectComb("bad_funct_zero_lit", SEL_ZERO, 32'd1);
    stepClock();
    applyStimulus("reserved_op", 2'b11, 6'h20, 32'd9, 32'd9, 2'b00, 32'd0, 1'b0, 1'b0);
    expectComb("reserved_op_ctl_lit", SEL_CTL, 32'hF);
    stepClock();
    applyStimulus("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd2, 2'b00, 32'd0, 1'b0, 1'b0);
    expectComb("add_wrap_lit", SEL_RESULT, 32'd1);
    stepClock();

    // Fetch sequence from a fresh reset
    resetDut();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus("fetch", 2'b00, 6'h00, model_pc, 32'd4, 2'b00, 32'd0, 1'b1, 1'b0);
      expectReg("fetch_pc_lit", SEL_PC, 32'(4 * i));
      stepClock();
    end

    applyStimulus("br_tgt", 2'b00, 6'h00, 32'd8, 32'h20, 2'b00, 32'd0, 1'b0, 1'b0);
    expectReg("br_tgt_aluout_lit", SEL_ALUOUT, 32'h28);
    stepClock();
    applyStimulus("br_taken", 2'b01, 6'h00, 32'd7, 32'd7, 2'b01, 32'd0, 1'b0, 1'b1);
    expectReg("br_taken_pc_lit", SEL_PC, 32'h28);
    stepClock();
    applyStimulus("br_tgt2", 2'b00, 6'h00, 32'd8, 32'h30, 2'b00, 32'd0, 1'b0, 1'b0);
    stepClock();
    applyStimulus("br_not", 2'b01, 6'h00, 32'd7, 32'd6, 2'b01, 32'd0, 1'b0, 1'b1);
    expectReg("br_not_pc_lit", SEL_PC, 32'h28);
    stepClock();

    applyStimulus("jump", 2'b00, 6'h00, 32'd1, 32'd1, 2'b10, 32'h0040_0100, 1'b1, 1'b0);
    expectReg("jump_pc_lit", SEL_PC, 32'h0040_0100);
    stepClock();
    applyStimulus("jump11", 2'b00, 6'h00, 32'd1, 32'd1, 2'b11, 32'h0040_0200, 1'b1, 1'b1);
    expectReg("jump11_pc_lit", SEL_PC, 32'h0040_0200);
    stepClock();

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      applyStimulus("rand", 2'($urandom_range(0, 3)), funct_pool[$urandom_range(0, 6)],
                    ra, rb, 2'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      stepClock();
    end

    // Mid-cycle reset with pc at 0x40, then a held reset across an edge
    applyStimulus("to40", 2'b00, 6'h00, 32'd0, 32'd0, 2'b10, 32'h40, 1'b1, 1'b0);
    expectReg("to40_pc_lit", SEL_PC, 32'h40);
    stepClock();
    #2;
    reset_n = 1'b0;
    #1;
    expectReg("midrst_pc", SEL_PC, 32'd0);
    expectReg("midrst_aluout", SEL_ALUOUT, 32'd0);
    drainReg();
    model_pc = RESET_PC;
    model_alu_out = 32'd0;
    applyStimulus("in_rst", 2'b00, 6'h00, 32'd3, 32'd4, 2'b10, 32'h80, 1'b1, 1'b0);
    expectComb("in_rst_result_lit", SEL_RESULT, 32'd7);
    expectReg("in_rst_pc_lit", SEL_PC, 32'd0);
    stepClock();
    reset_n = 1'b1;
    applyStimulus("post_rst", 2'b00, 6'h00, 32'd3, 32'd4, 2'b10, 32'h80, 1'b1, 1'b0);
    expectReg("post_rst_pc_lit", SEL_PC, 32'h80);
    expectReg("post_rst_aluout_lit", SEL_ALUOUT, 32'd7);
    stepClock();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_alu_pc_unit.md
MIPS_ALU_PC_UNIT -- requirements
Module: mips_alu_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into the PC register on reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 alu_op  input  2  instruction class from control: 00 add, 01 subtract, 10 decode funct, 11 reserved.
REQ-005 funct  input  6  function field IR[5:0].
REQ-006 alu_a  input  32  ALU operand A (PC or rs, selected upstream).
REQ-007 alu_b  input  32  ALU operand B (rt, 4, or an immediate, selected upstream).
REQ-008 pc_source  input  2  next-PC select: 00 ALU result, 01 registered ALUOut, 10 jump target.
REQ-009 jump_addr  input  32  composed jump target.
REQ-010 pc_write  input  1  unconditional PC load enable.
REQ-011 pc_write_cond  input  1  PC load enable qualified by zero (branch-equal).
REQ-012 alu_ctl  output  4  decoded ALU control lines, combinational.
REQ-013 alu_result  output  32  ALU result, combinational.
REQ-014 zero  output  1  high when alu_result == 0, combinational.
REQ-015 alu_out  output  32  ALU result registered every cycle (ALUOut).
REQ-016 pc_next  output  32  output of the 3-to-1 PC source mux, combinational.
REQ-017 pc  output  32  program counter register.

Function
REQ-018 ALU control SHALL map alu_op 00 -> 0010, alu_op 01 -> 0110, alu_op 11 -> 1111, independent of funct.
REQ-019 For alu_op 10, funct SHALL decode as: 100000 -> 0010 (add), 100010 -> 0110 (sub), 100100 -> 0000 (and), 100101 -> 0001 (or), 100111 -> 1100 (nor), 101010 -> 0111 (slt); any other funct -> 1111.
REQ-020 ALU SHALL compute: 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 0111 32'd1 if a<b as signed two's-complement else 32'd0; 1100 ~(a|b); any other code -> 32'd0.
REQ-021 Add and subtract SHALL wrap modulo 2^32; no overflow detection or trap.
REQ-022 zero SHALL equal (alu_result == 32'd0) for every code, including unused codes (zero = 1).
REQ-023 pc_next SHALL be alu_result for pc_source 00, alu_out for 01, and jump_addr for 10 and 11.
REQ-024 On every rising clock edge out of reset, alu_out SHALL load alu_result, with no enable.
REQ-025 On a rising edge, pc SHALL load pc_next iff pc_write | (pc_write_cond & zero); otherwise pc holds.
REQ-026 When pc_write and pc_write_cond are both high, pc SHALL load regardless of zero.
REQ-027 The zero used in REQ-025 SHALL be the combinational value in the same cycle; no extra latency.
REQ-028 alu_out SHALL be one-cycle-delayed alu_result, so pc_source 01 selects the previous cycle's result (the branch target).
REQ-029 All combinational outputs SHALL settle within the same cycle their inputs change; there are no internal states or handshakes.

Reset
REQ-030 While reset_n is low, pc SHALL equal RESET_PC and alu_out SHALL equal 32'd0, asynchronously and independent of clock.
REQ-031 Combinational outputs (alu_ctl, alu_result, zero, pc_next) SHALL remain functional during reset.
REQ-032 After reset_n rises, the first rising edge SHALL perform normal updates per REQ-024/025.
REQ-033 Asserting reset_n low mid-operation SHALL discard any pending PC or alu_out load.

Verification
REQ-034 alu_op 10, funct 100010, a=5, b=5 -> alu_ctl 0110, alu_result 0, zero 1; alu_op 10, funct 101010, a=32'hFFFF_FFFF, b=1 -> alu_result 1.
REQ-035 alu_op 10, funct 100111, a=32'h0F0F_0000, b=32'h0000_00F0 -> alu_result 32'hF0F0_FF0F; alu_op 10, funct 000000 -> alu_ctl 1111, alu_result 0, zero 1.
REQ-036 Fetch: reset, then alu_op 00, a=pc, b=4, pc_source 00, pc_write 1 for 3 edges -> pc 4, 8, 12; alu_out tracks a+b.
REQ-037 Branch: cycle 1 alu_op 00, a=8, b=32'h20 -> alu_out 32'h28; cycle 2 alu_op 01, a=b=7, pc_source 01, pc_write_cond 1 -> pc 32'h28; repeat with a=7, b=6 -> pc unchanged.
REQ-038 Jump: pc_source 10, jump_addr 32'h0040_0100, pc_write 1 -> pc 32'h0040_0100 after one edge; pc_source 11 gives the same.
REQ-039 Assert reset_n low between clock edges with pc=32'h40 -> pc 0 and alu_out 0 immediately, with no clock edge required.
